branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 135 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution with a one-cycle registered result and an optional circular return-address stack.
// The RAS is built only when the macro BRANCH_RAS_EN is defined; otherwise CALL/RET redirect to target_i.
module branch_resolve_unit #(
    parameter int XLEN      = 19,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            is_b_type_ctl_i,
    input  logic [2:0]      instr_func3_ctl_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] target_o,
    output logic            ras_overflow_o,
    output logic            ras_underflow_o
);

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_BLT  = 3'd4;
    localparam logic [2:0] OP_BGE  = 3'd5;
    localparam logic [2:0] OP_BLTU = 3'd6;
    localparam logic [2:0] OP_BGEU = 3'd7;

    logic            accept;
    logic            cond_taken;
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] next_target;

    assign accept  = valid_i & ~flush_i;
    assign is_call = accept & is_b_type_ctl_i & (instr_func3_ctl_i == OP_CALL);
    assign is_ret  = accept & is_b_type_ctl_i & (instr_func3_ctl_i == OP_RET);

    always_comb begin
        cond_taken = 1'b0;
        case (instr_func3_ctl_i)
            OP_BEQ:  cond_taken = (opr_a_i == opr_b_i);
            OP_BNE:  cond_taken = (opr_a_i != opr_b_i);
            OP_BLT:  cond_taken = ($signed(opr_a_i) <  $signed(opr_b_i));
            OP_BGE:  cond_taken = ($signed(opr_a_i) >= $signed(opr_b_i));
            OP_BLTU: cond_taken = (opr_a_i <  opr_b_i);
            OP_BGEU: cond_taken = (opr_a_i >= opr_b_i);
            default: cond_taken = 1'b1;
        endcase
    end

`ifdef BRANCH_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    // ras_ptr is the next free slot; the top entry sits one below it, wrapping naturally.
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic [PTR_W-1:0] top_idx;
    logic             ras_full;
    logic             ras_empty;
    logic             next_overflow;
    logic             next_underflow;

    assign top_idx   = ras_ptr - PTR_W'(1);
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (is_call) begin
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (!ras_full) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (is_ret && !ras_empty) begin
            ras_ptr <= top_idx;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

    // When full, the next free slot is also the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (is_call) begin
            ras_mem[ras_ptr] <= pc_i + XLEN'(1);
        end
    end

    always_comb begin
        next_target    = target_i;
        next_overflow  = is_call & ras_full;
        next_underflow = is_ret & ras_empty;
        if (is_ret && !ras_empty) begin
            next_target = ras_mem[top_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_overflow_o  <= 1'b0;
            ras_underflow_o <= 1'b0;
        end else begin
            ras_overflow_o  <= next_overflow;
            ras_underflow_o <= next_underflow;
        end
    end
`else
    logic unused_pc;

    assign unused_pc       = ^pc_i;
    assign next_target     = target_i;
    assign ras_overflow_o  = 1'b0;
    assign ras_underflow_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_o        <= 1'b0;
            branch_taken_o <= 1'b0;
            target_o       <= '0;
        end else begin
            valid_o        <= accept;
            branch_taken_o <= accept & is_b_type_ctl_i & cond_taken;
            target_o       <= next_target;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic
// checked against a queue-based model; RAS expectations follow the BRANCH_RAS_EN macro.
module tb_branch_resolve_unit;

    localparam int XLEN      = 19;
    localparam int RAS_DEPTH = 4;

    typedef struct packed {
        logic            v;
        logic            t;
        logic [XLEN-1:0] tgt;
        logic            ovf;
        logic            unf;
    } res_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            valid_i;
    logic [XLEN-1:0] opr_a_i;
    logic [XLEN-1:0] opr_b_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] target_i;
    logic            is_b_type_ctl_i;
    logic [2:0]      instr_func3_ctl_i;
    logic            flush_i;
    logic            valid_o;
    logic            branch_taken_o;
    logic [XLEN-1:0] target_o;
    logic            ras_overflow_o;
    logic            ras_underflow_o;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] ras_q [$];

    branch_resolve_unit #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .valid_i          (valid_i),
        .opr_a_i          (opr_a_i),
        .opr_b_i          (opr_b_i),
        .pc_i             (pc_i),
        .target_i         (target_i),
        .is_b_type_ctl_i  (is_b_type_ctl_i),
        .instr_func3_ctl_i(instr_func3_ctl_i),
        .flush_i          (flush_i),
        .valid_o          (valid_o),
        .branch_taken_o   (branch_taken_o),
        .target_o         (target_o),
        .ras_overflow_o   (ras_overflow_o),
        .ras_underflow_o  (ras_underflow_o)
    );

    always #5 clk = ~clk;

    function automatic longint sval(input logic [XLEN-1:0] x);
        longint r = longint'(x);
        if (r >= (longint'(1) << (XLEN - 1))) r = r - (longint'(1) << XLEN);
        return r;
    endfunction

    // Reference model: the RAS is a bounded queue of return addresses, newest at the back.
    function automatic res_t model_step(input logic v, input logic fl, input logic bt,
                                        input logic [2:0] f, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                                        input logic [XLEN-1:0] tg);
        res_t r = '0;
        if (!v || fl) return r;
        r.v = 1'b1;
        if (!bt) return r;
        r.tgt = tg;
        case (f)
            3'd0: r.t = (longint'(a) == longint'(b));
            3'd1: r.t = (longint'(a) != longint'(b));
            3'd4: r.t = (sval(a) <  sval(b));
            3'd5: r.t = (sval(a) >= sval(b));
            3'd6: r.t = (longint'(a) <  longint'(b));
            3'd7: r.t = (longint'(a) >= longint'(b));
            3'd2: begin
                r.t = 1'b1;
`ifdef BRANCH_RAS_EN
                ras_q.push_back(XLEN'((longint'(pc) + 1) % (longint'(1) << XLEN)));
                if (ras_q.size() > RAS_DEPTH) begin
                    void'(ras_q.pop_front());
                    r.ovf = 1'b1;
                end
`endif
            end
            default: begin
                r.t = 1'b1;
`ifdef BRANCH_RAS_EN
                if (ras_q.size() > 0) r.tgt = ras_q.pop_back();
                else r.unf = 1'b1;
`endif
            end
        endcase
        if (!r.t) r.tgt = '0;
        return r;
    endfunction

    function automatic res_t sample_outputs();
        res_t r;
        r.v   = valid_o;
        r.t   = branch_taken_o;
        r.tgt = (valid_o && branch_taken_o) ? target_o : '0;
        r.ovf = ras_overflow_o;
        r.unf = ras_underflow_o;
        return r;
    endfunction

    task automatic applyStimulus(input logic v, input logic fl, input logic bt, input logic [2:0] f,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tg);
        valid_i           = v;
        flush_i           = fl;
        is_b_type_ctl_i   = bt;
        instr_func3_ctl_i = f;
        opr_a_i           = a;
        opr_b_i           = b;
        pc_i              = pc;
        target_i          = tg;
    endtask

    task automatic step(input logic v, input logic fl, input logic bt, input logic [2:0] f,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tg,
                        output res_t obs, output res_t exp);
        applyStimulus(v, fl, bt, f, a, b, pc, tg);
        @(posedge clk);
        exp = model_step(v, fl, bt, f, a, b, pc, tg);
        #1;
        obs = sample_outputs();
    endtask

    task automatic test_reset();
        res_t obs;
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, '0, '0, 19'h00010, 19'h00020);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            obs = sample_outputs();
            checks++;
            if (obs !== '0 || target_o !== '0) begin
                errors++;
                $display("[TB] FAIL reset_hold: got %h target %h, expected all zero", obs, target_o);
            end
        end
        ras_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_compare_vectors();
        res_t obs, exp;
        logic [2:0] ops [3] = '{3'd4, 3'd6, 3'd7};
        logic       want [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, ops[i], 19'h7FFFF, 19'h00001, 19'h00040, 19'h00444, obs, exp);
            checks++;
            if (obs.v !== 1'b1 || obs.t !== want[i] || obs !== exp) begin
                errors++;
                $display("[TB] FAIL cmp_op%0d: got %h expected %h (taken %b)", ops[i], obs, exp, want[i]);
            end
        end
        step(1'b0, 1'b0, 1'b1, 3'd4, 19'h7FFFF, 19'h00001, '0, '0, obs, exp);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL cmp_one_cycle: got %h expected 0", obs);
        end
    endtask

    task automatic test_call_ret();
        res_t obs, exp;
        logic [XLEN-1:0] ret_tgt;
`ifdef BRANCH_RAS_EN
        ret_tgt = 19'h00101;
`else
        ret_tgt = 19'h00555;
`endif
        step(1'b1, 1'b0, 1'b1, 3'd2, '0, '0, 19'h00100, 19'h00200, obs, exp);
        checks++;
        if (obs !== exp || obs.tgt !== 19'h00200 || !obs.t) begin
            errors++;
            $display("[TB] FAIL call: got %h expected %h", obs, exp);
        end
        step(1'b1, 1'b0, 1'b1, 3'd3, '0, '0, 19'h00300, 19'h00555, obs, exp);
        checks++;
        if (obs !== exp || obs.tgt !== ret_tgt || obs.unf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ret_after_call: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_ras_overflow();
        res_t obs, exp;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd2, '0, '0, XLEN'(10 * i), XLEN'(100 + i), obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL ovf_call%0d: got %h expected %h", i, obs, exp);
            end
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd3, '0, '0, '0, XLEN'(700 + i), obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL ovf_ret%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_flush_and_nonbranch();
        res_t obs, exp;
        step(1'b1, 1'b1, 1'b1, 3'd2, '0, '0, 19'h00050, 19'h00060, obs, exp);
        checks++;
        if (obs !== exp || obs.v !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flushed_call: got %h expected %h", obs, exp);
        end
        step(1'b0, 1'b1, 1'b1, 3'd3, '0, '0, '0, 19'h00061, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL idle_flush: got %h expected %h", obs, exp);
        end
        step(1'b1, 1'b0, 1'b0, 3'd2, '0, '0, 19'h00070, 19'h00071, obs, exp);
        checks++;
        if (obs !== exp || obs.v !== 1'b1 || obs.t !== 1'b0) begin
            errors++;
            $display("[TB] FAIL non_branch: got %h expected %h", obs, exp);
        end
        step(1'b1, 1'b0, 1'b1, 3'd3, '0, '0, '0, 19'h00072, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL ret_after_flush: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_mid_reset();
        res_t obs, exp;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 3'd2, '0, '0, XLEN'(300 + i), XLEN'(400 + i), obs, exp);
        end
        reset_n = 1'b0;
        ras_q.delete();
        #1;
        obs = sample_outputs();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 0", obs);
        end
        @(posedge clk);
        #1;
        obs = sample_outputs();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_edge: got %h expected 0", obs);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b1, 3'd3, '0, '0, '0, 19'h00123, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL ret_after_reset: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_random();
        res_t obs, exp;
        logic [XLEN-1:0] a, b;
        logic [2:0] f;
        for (int i = 0; i < 400; i++) begin
            a = XLEN'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom);
            f = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0,
                 f, a, b, XLEN'($urandom), XLEN'($urandom), obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL random%0d op%0d: got %h expected %h", i, f, obs, exp);
            end
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0);
        test_reset();
        test_compare_vectors();
        test_call_ret();
        test_ras_overflow();
        test_flush_and_nonbranch();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
